nios_cpu_xb_gpio_conditioner: RTL

// - Input conditioner for the expansion-board (XB) GPIO pins; sits directly upstream of the XB GPIO Avalon PIO.
// - Per bit: synchronises raw asynchronous pins, optionally debounces them, and drives the stable bus into the PIO in_port.
// - Also flags rising/falling edges with sticky W1C pending bits and a maskable level interrupt to the Nios.

---
 rtl/nios_cpu_xb_gpio_conditioner_if.sv | 39 +++
 rtl/nios_cpu_xb_gpio_conditioner.sv | 88 ++++++++
 2 files changed

// File: rtl/nios_cpu_xb_gpio_conditioner_if.sv
// XB GPIO conditioner bus: raw pins and controls in, conditioned levels,
// edge strobes, pending flags and irq out.
interface nios_cpu_xb_gpio_conditioner_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] pins_in;
    logic             debounce_en;
    logic [WIDTH-1:0] stable_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] edge_pending;
    logic [WIDTH-1:0] edge_clear;
    logic [WIDTH-1:0] irq_mask;
    logic             irq;

    modport master (
        output pins_in,
        output debounce_en,
        output edge_clear,
        output irq_mask,
        input  stable_out,
        input  rise_pulse,
        input  fall_pulse,
        input  edge_pending,
        input  irq
    );

    modport slave (
        input  pins_in,
        input  debounce_en,
        input  edge_clear,
        input  irq_mask,
        output stable_out,
        output rise_pulse,
        output fall_pulse,
        output edge_pending,
        output irq
    );
endinterface

// File: rtl/nios_cpu_xb_gpio_conditioner.sv
// XB GPIO input conditioner: per-bit synchroniser, optional debounce,
// edge strobes, sticky W1C pending flags and a maskable level irq.
module nios_cpu_xb_gpio_conditioner #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input logic clk,
    input logic reset_n,
    nios_cpu_xb_gpio_conditioner_if.slave bus
);
    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] pend_q, pend_d;

    // Plain flop chain; nothing between stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= bus.pins_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (!bus.debounce_en) begin
                stable_d[i] = sync[i];
            end else if (sync[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise_d = stable_d & ~stable_q;
        fall_d = ~stable_d & stable_q;
        // Set wins over a same-cycle clear so no edge is lost.
        pend_d = (pend_q & ~bus.edge_clear) | rise_q | fall_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            pend_q   <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            pend_q   <= pend_d;
        end
    end

    assign bus.stable_out   = stable_q;
    assign bus.rise_pulse   = rise_q;
    assign bus.fall_pulse   = fall_q;
    assign bus.edge_pending = pend_q;
    assign bus.irq          = |(pend_q & bus.irq_mask);
endmodule
